// File: rtl/cache_refill_arbiter.sv
// Shares one word-wide memory port between the I- and D-caches: round-robin
// arbitration, then a BLOCKS-word burst that fills or drains one cache block.
module cache_refill_arbiter #(
    parameter int BLOCKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [31:0]             i_addr,
    output logic [BLOCKS-1:0][31:0] i_rblock,
    output logic                    i_done,
    output logic                    i_miss,
    input  logic                    d_req,
    input  logic [31:0]             d_addr,
    input  logic                    d_we,
    input  logic [BLOCKS-1:0][31:0] d_wblock,
    output logic [BLOCKS-1:0][31:0] d_rblock,
    output logic                    d_done,
    output logic                    d_miss,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    output logic                    mem_we,
    output logic [31:0]             mem_wd,
    input  logic [31:0]             mem_rd,
    input  logic                    mem_wait
);
    localparam int CW = $clog2(BLOCKS);
    localparam logic [31:0] BASE_MASK = ~(32'(4 * BLOCKS) - 32'd1);
    localparam logic [CW-1:0] LAST = CW'(BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    gnt_d_q, gnt_d_d;   // current transfer belongs to the D-cache
    logic                    last_d_q, last_d_d; // previous transfer belonged to the D-cache
    logic                    we_q, we_d;
    logic [31:0]             base_q, base_d;
    logic [BLOCKS-1:0][31:0] wblock_q, wblock_d;
    logic [BLOCKS-1:0][31:0] i_rblock_q, i_rblock_d;
    logic [BLOCKS-1:0][31:0] d_rblock_q, d_rblock_d;
    logic                    pick_d;

    // On a tie the requester that did not win last time gets the port.
    assign pick_d = d_req && (!i_req || !last_d_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d_d    = gnt_d_q;
        last_d_d   = last_d_q;
        we_d       = we_q;
        base_d     = base_q;
        wblock_d   = wblock_q;
        i_rblock_d = i_rblock_q;
        d_rblock_d = d_rblock_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = XFER;
                    cnt_d   = '0;
                    gnt_d_d = pick_d;
                    base_d  = (pick_d ? d_addr : i_addr) & BASE_MASK;
                    we_d    = pick_d && d_we;
                    if (pick_d && d_we) wblock_d = d_wblock;
                end
            end
            XFER: begin
                if (!mem_wait) begin
                    if (!we_q) begin
                        if (gnt_d_q) d_rblock_d[cnt_q] = mem_rd;
                        else         i_rblock_d[cnt_q] = mem_rd;
                    end
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Requests are deliberately not sampled here so the finished
                // requester has a cycle to drop req.
                last_d_d = gnt_d_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_d_q    <= 1'b0;
            last_d_q   <= 1'b0;
            we_q       <= 1'b0;
            base_q     <= '0;
            wblock_q   <= '0;
            i_rblock_q <= '0;
            d_rblock_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_d_q    <= gnt_d_d;
            last_d_q   <= last_d_d;
            we_q       <= we_d;
            base_q     <= base_d;
            wblock_q   <= wblock_d;
            i_rblock_q <= i_rblock_d;
            d_rblock_q <= d_rblock_d;
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        if (state_q == XFER) begin
            mem_req  = 1'b1;
            mem_addr = base_q + {{(30 - CW){1'b0}}, cnt_q, 2'b00};
            mem_we   = we_q;
            mem_wd   = wblock_q[cnt_q];
        end
    end

    assign i_done   = (state_q == DONE) && !gnt_d_q;
    assign d_done   = (state_q == DONE) && gnt_d_q;
    assign i_miss   = i_req & ~i_done;
    assign d_miss   = d_req & ~d_done;
    assign i_rblock = i_rblock_q;
    assign d_rblock = d_rblock_q;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and block transfers.
module tb_cache_refill_arbiter;
    localparam int B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, i_req, d_req, d_we, i_done, d_done, i_miss, d_miss;
    logic [31:0]        i_addr, d_addr;
    logic [B-1:0][31:0] d_wblock, i_rblock, d_rblock;
    logic               mem_req, mem_we, mem_wait;
    logic [31:0]        mem_addr, mem_wd, mem_rd;
    logic [31:0]        salt, wait_addr;
    logic               rand_wait;
    int                 wait_n, wait_used;
    int                 n_chk, n_fail;

    cache_refill_arbiter #(.BLOCKS(B)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rblock(i_rblock), .i_done(i_done), .i_miss(i_miss),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wblock(d_wblock),
        .d_rblock(d_rblock), .d_done(d_done), .d_miss(d_miss),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_wait(mem_wait)
    );

    // Memory model: read data is a salted function of the word address.
    assign mem_rd = mem_addr ^ salt;

    // Wait-state generator: random in random mode, else wait_n stalls on wait_addr.
    initial begin
        mem_wait  = 1'b0;
        wait_used = 0;
        forever begin
            @(posedge clk); #1;
            if (rand_wait) mem_wait = ($urandom_range(0, 2) == 0);
            else if (mem_req && mem_addr == wait_addr && wait_used < wait_n) begin
                mem_wait = 1'b1;
                wait_used++;
            end else mem_wait = 1'b0;
        end
    end

    typedef struct packed { logic [31:0] a; logic we; logic [31:0] wd; } acc_t;
    acc_t acc_q[$];
    always @(negedge clk) if (mem_req && !mem_wait) acc_q.push_back('{mem_addr, mem_we, mem_wd});

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [B-1:0][31:0] rd_block(input logic [31:0] a);
        logic [B-1:0][31:0] r;
        logic [31:0] base;
        base = a & ~32'(4 * B - 1);
        for (int k = 0; k < B; k++) r[k] = (base + 32'(4 * k)) ^ salt;
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b1; d_req = 1'b0;
        tick();
        n_chk++; if ({mem_req, mem_we, i_done, d_done} !== 4'b0) begin n_fail++;
            $display("FAIL reset_ctl got %b want 0000", {mem_req, mem_we, i_done, d_done}); end
        n_chk++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin n_fail++;
            $display("FAIL reset_bus got addr %h wd %h want 0", mem_addr, mem_wd); end
        n_chk++; if (i_rblock !== '0 || d_rblock !== '0) begin n_fail++;
            $display("FAIL reset_rblock got %h / %h want 0", i_rblock, d_rblock); end
        n_chk++; if (i_miss !== 1'b1 || d_miss !== 1'b0) begin n_fail++;
            $display("FAIL reset_miss got %b%b want 10", i_miss, d_miss); end
        i_req = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        salt = 32'h0; i_addr = 32'h44; i_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) i_req = 1'b0;
            n_chk++;
            if (mem_req !== (k <= 4) || (k <= 4 && mem_addr !== 32'h40 + 32'(4 * (k - 1)))) begin
                n_fail++; $display("FAIL single_mem k=%0d got req %b addr %h", k, mem_req, mem_addr); end
            n_chk++; if (i_done !== (k == 5) || d_done !== 1'b0) begin n_fail++;
                $display("FAIL single_done k=%0d got %b%b want %b0", k, i_done, d_done, k == 5); end
            if (k == 5) begin
                n_chk++; if (i_miss !== 1'b0) begin n_fail++;
                    $display("FAIL single_miss got %b want 0", i_miss); end
                n_chk++; if (i_rblock !== {32'h4C, 32'h48, 32'h44, 32'h40}) begin n_fail++;
                    $display("FAIL single_rblock got %h", i_rblock); end
            end
        end
    endtask

    task automatic test_tie();
        do_reset();
        salt = 32'h1234_0000; i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            i_req = 1'b1; d_req = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (k == 6) d_req = 1'b0;
                if (k == 12) i_req = 1'b0;
                n_chk++; if (d_done !== (k == 5) || i_done !== (k == 11)) begin n_fail++;
                    $display("FAIL tie_done rep=%0d k=%0d got i%b d%b", rep, k, i_done, d_done); end
                if (k == 7) begin
                    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_fail++;
                        $display("FAIL tie_igrant got req %b addr %h want 1 00000200", mem_req, mem_addr); end
                end
                if (k == 11) begin
                    n_chk++; if (i_rblock !== rd_block(32'h200) || d_rblock !== rd_block(32'h300)) begin
                        n_fail++; $display("FAIL tie_rblock got %h / %h", i_rblock, d_rblock); end
                end
            end
            tick();
        end
    endtask

    task automatic test_writeback();
        logic [B-1:0][31:0] exp_d;
        exp_d = rd_block(32'h300);
        d_addr = 32'h100; d_we = 1'b1; d_wblock = {32'd4, 32'd3, 32'd2, 32'd1}; d_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) d_req = 1'b0;
            n_chk++;
            if (k <= 4) begin
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * (k - 1))
                    || mem_wd !== 32'(k)) begin n_fail++;
                    $display("FAIL wb_word k=%0d got req %b we %b addr %h wd %h", k, mem_req, mem_we, mem_addr, mem_wd); end
            end else if ({mem_req, mem_we} !== 2'b00 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin n_fail++;
                $display("FAIL wb_idle k=%0d got req %b we %b addr %h wd %h", k, mem_req, mem_we, mem_addr, mem_wd); end
            n_chk++; if (d_done !== (k == 5)) begin n_fail++;
                $display("FAIL wb_done k=%0d got %b", k, d_done); end
            if (k == 5) begin
                n_chk++; if (d_rblock !== exp_d || i_rblock !== rd_block(32'h200)) begin n_fail++;
                    $display("FAIL wb_rblock got %h / %h", d_rblock, i_rblock); end
            end
        end
        d_we = 1'b0;
    endtask

    task automatic test_wait();
        logic [31:0] tbl [6];
        tbl = '{32'h80, 32'h84, 32'h88, 32'h88, 32'h88, 32'h8C};
        salt = $urandom; i_addr = 32'h80; wait_addr = 32'h88; wait_n = 2; i_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) i_req = 1'b0;
            if (k <= 6) begin
                n_chk++; if (mem_req !== 1'b1 || mem_addr !== tbl[k-1]) begin n_fail++;
                    $display("FAIL wait_addr k=%0d got %b %h want 1 %h", k, mem_req, mem_addr, tbl[k-1]); end
            end
            n_chk++; if (i_done !== (k == 7)) begin n_fail++;
                $display("FAIL wait_done k=%0d got %b", k, i_done); end
            if (k == 7) begin
                n_chk++; if (i_rblock !== rd_block(32'h80)) begin n_fail++;
                    $display("FAIL wait_rblock got %h want %h", i_rblock, rd_block(32'h80)); end
            end
        end
        wait_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset_mid();
        salt = $urandom; i_addr = 32'h500; i_req = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        n_chk++; if (i_rblock[0] !== (32'h500 ^ salt)) begin n_fail++;
            $display("FAIL rmid_partial got %h want %h", i_rblock[0], 32'h500 ^ salt); end
        reset = 1'b1; #1;
        n_chk++; if (mem_req !== 1'b0 || i_rblock !== '0 || d_rblock !== '0 || i_done !== 1'b0) begin n_fail++;
            $display("FAIL rmid_abort got req %b done %b rblk %h / %h", mem_req, i_done, i_rblock, d_rblock); end
        tick();
        n_chk++; if (i_done !== 1'b0 || mem_req !== 1'b0) begin n_fail++;
            $display("FAIL rmid_hold got done %b req %b", i_done, mem_req); end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) i_req = 1'b0;
            n_chk++; if (i_done !== (k == 5)) begin n_fail++;
                $display("FAIL rmid_done k=%0d got %b", k, i_done); end
            if (k == 5) begin
                n_chk++; if (i_rblock !== rd_block(32'h500)) begin n_fail++;
                    $display("FAIL rmid_rblock got %h want %h", i_rblock, rd_block(32'h500)); end
            end
        end
    endtask

    task automatic test_req_drop();
        i_addr = 32'h600; i_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) begin i_req = 1'b0; i_addr = 32'hDEAD_BEEF; end
            n_chk++; if (mem_req !== (k <= 4) || i_done !== (k == 5)) begin n_fail++;
                $display("FAIL drop k=%0d got req %b done %b", k, mem_req, i_done); end
            if (k == 5) begin
                n_chk++; if (i_rblock !== rd_block(32'h600)) begin n_fail++;
                    $display("FAIL drop_rblock got %h want %h", i_rblock, rd_block(32'h600)); end
            end
        end
    endtask

    task automatic test_random();
        logic [B-1:0][31:0] m_i, m_d;
        logic               m_last_d;
        do_reset();
        m_i = '0; m_d = '0; m_last_d = 1'b0; rand_wait = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic wi, wd, dwe, first_d, fi, fd, exp_is_d;
            logic [31:0] ia, da, base;
            logic [B-1:0][31:0] wb;
            int total, got, a0;
            acc_t exp_q[$];
            wi = 1'b0; wd = 1'b0;
            case ($urandom_range(0, 2))
                0: wi = 1'b1;
                1: wd = 1'b1;
                default: begin wi = 1'b1; wd = 1'b1; end
            endcase
            salt = $urandom; ia = $urandom; da = $urandom; dwe = 1'($urandom_range(0, 1));
            for (int k = 0; k < B; k++) wb[k] = $urandom;
            if (it == 0) begin ia = 32'hFFFF_FFFF; da = 32'hFFFF_FFF5; wi = 1'b1; wd = 1'b1; end
            total = int'(wi) + int'(wd);
            first_d = wd && (!wi || !m_last_d);
            for (int t = 0; t < total; t++) begin
                logic is_d;
                is_d = (t == 0) ? first_d : !first_d;
                base = (is_d ? da : ia) & ~32'(4 * B - 1);
                for (int k = 0; k < B; k++)
                    exp_q.push_back('{base + 32'(4 * k), is_d && dwe, (is_d && dwe) ? wb[k] : 32'h0});
                m_last_d = is_d;
            end
            i_addr = ia; d_addr = da; d_we = dwe; d_wblock = wb;
            a0 = acc_q.size(); got = 0; fi = 1'b0; fd = 1'b0;
            i_req = wi; d_req = wd;
            for (int cy = 0; cy < 400 && got < total; cy++) begin
                tick();
                if (fi) i_req = 1'b0;
                if (fd) d_req = 1'b0;
                fi = 1'b0; fd = 1'b0;
                if (i_done || d_done) begin
                    exp_is_d = (got == 0) ? first_d : !first_d;
                    n_chk++; if ({i_done, d_done} !== (exp_is_d ? 2'b01 : 2'b10)) begin n_fail++;
                        $display("FAIL rand_order it=%0d got i%b d%b", it, i_done, d_done); end
                    if (i_done) begin fi = 1'b1; m_i = rd_block(ia); end
                    if (d_done) begin fd = 1'b1; if (!dwe) m_d = rd_block(da); end
                    n_chk++; if (i_rblock !== m_i || d_rblock !== m_d) begin n_fail++;
                        $display("FAIL rand_rblock it=%0d got %h / %h want %h / %h", it, i_rblock, d_rblock, m_i, m_d); end
                    got++;
                end
            end
            n_chk++; if (got != total) begin n_fail++;
                $display("FAIL rand_timeout it=%0d got %0d dones want %0d", it, got, total); end
            tick();
            i_req = 1'b0; d_req = 1'b0;
            tick();
            n_chk++; if (mem_req !== 1'b0) begin n_fail++;
                $display("FAIL rand_extra_grant it=%0d got req %b want 0", it, mem_req); end
            n_chk++;
            if (acc_q.size() - a0 != exp_q.size()) begin n_fail++;
                $display("FAIL rand_count it=%0d got %0d accesses want %0d", it, acc_q.size() - a0, exp_q.size()); end
            else for (int j = 0; j < exp_q.size(); j++) begin
                n_chk++;
                if (acc_q[a0+j].a !== exp_q[j].a || acc_q[a0+j].we !== exp_q[j].we
                    || (exp_q[j].we && acc_q[a0+j].wd !== exp_q[j].wd)) begin n_fail++;
                    $display("FAIL rand_acc it=%0d j=%0d got %h/%b/%h want %h/%b/%h", it, j,
                             acc_q[a0+j].a, acc_q[a0+j].we, acc_q[a0+j].wd, exp_q[j].a, exp_q[j].we, exp_q[j].wd); end
            end
        end
        rand_wait = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wblock = '0; salt = '0;
        rand_wait = 1'b0; wait_addr = 32'hFFFF_FFFF; wait_n = 0;
        test_reset();
        test_single_read();
        test_tie();
        test_writeback();
        test_wait();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
